npu_sched: RTL and testbench

NPU_SCHED -- requirements
Module: npu_sched

---
 rtl/npu_sched.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_npu_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_sched.sv
// npu_sched: layer scheduler for the NPU.
// Host commands go into a small FIFO. Each command describes one layer and is
// handed to the local-memory controller as a registered configuration plus a
// one-cycle LM_START pulse. The FSM then waits for LM_FINISH, with a timeout
// that flushes the queue and raises a sticky error.
module npu_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic                    CLK,
    input  logic                    RESET_X,
    input  logic                    SOFT_RESET,
    input  logic                    CMD_WR,
    input  logic [1:0]              CMD_A_SEL,
    input  logic [1:0]              CMD_B_SEL,
    input  logic [1:0]              CMD_C_SEL,
    input  logic [9:0]              CMD_M1POS,
    input  logic [9:0]              CMD_M1SIZE,
    input  logic [9:0]              CMD_M2POS,
    input  logic [9:0]              CMD_M3POS,
    input  logic                    RUN,
    input  logic                    ERR_CLR,
    output logic [$clog2(DEPTH):0]  CMD_CNT,
    output logic                    CMD_FULL,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR,
    output logic                    OVF,
    output logic [7:0]              LAYER_CNT,
    output logic                    LM_START,
    input  logic                    LM_FINISH,
    output logic [1:0]              MSEL_INPUTA_SEL,
    output logic [1:0]              MSEL_INPUTB_SEL,
    output logic [1:0]              MSEL_OUTPUTC_SEL,
    output logic [9:0]              M1POS,
    output logic [9:0]              M1SIZE,
    output logic [9:0]              M2POS,
    output logic [9:0]              M3POS
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned CMD_W = 46;

    // The counter is compared before its increment, so the error fires on the
    // cycle in which the count would reach TIMEOUT-1.
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [CMD_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      wr_ptr_next;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW-1:0]      rd_ptr_next;
    logic [CW-1:0]      cnt_reg;
    logic [CW-1:0]      cnt_next;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [7:0]         layer_cnt_reg;
    logic               err_reg;
    logic               ovf_reg;
    logic [CMD_W-1:0]   cfg_reg;

    logic               soft_clr;
    logic [CMD_W-1:0]   cmd_word;
    logic               queue_empty;
    logic               queue_full;
    logic               pop;
    logic               push_ok;
    logic               ovf_set;
    logic               issue;
    logic               finish_hit;
    logic               timeout_hit;
    logic               busy_int;
    logic               done_int;

    assign soft_clr = ~SOFT_RESET;
    assign cmd_word = {CMD_A_SEL, CMD_B_SEL, CMD_C_SEL,
                       CMD_M1POS, CMD_M1SIZE, CMD_M2POS, CMD_M3POS};

    // Queue control. A push is accepted while full only when the head is
    // being popped in the same cycle, so the slot it frees is reused at once.
    assign queue_empty = (cnt_reg == '0);
    assign queue_full  = (cnt_reg == CNT_FULL);
    assign pop         = (state_reg == ST_LOAD) && !queue_empty;
    assign push_ok     = CMD_WR && (!queue_full || pop);
    assign ovf_set     = CMD_WR && !push_ok;

    // State register.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state_reg <= ST_IDLE;
        end else if (soft_clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; RUN is only consulted at layer boundaries, so a
    // layer in flight always runs to completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (RUN && !queue_empty && !err_reg) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (LM_FINISH) begin
                    state_next = (RUN && !queue_empty) ? ST_LOAD : ST_IDLE;
                end else if (to_cnt_reg == TO_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs. Pulses are masked while the synchronous reset is held so
    // the controller never sees a handshake from a state about to be cleared.
    always_comb begin
        issue       = 1'b0;
        finish_hit  = 1'b0;
        timeout_hit = 1'b0;
        busy_int    = 1'b0;
        done_int    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy_int = 1'b0;
            end
            ST_LOAD: begin
                busy_int = 1'b1;
            end
            ST_ISSUE: begin
                busy_int = 1'b1;
                issue    = 1'b1;
            end
            ST_WAIT: begin
                busy_int    = 1'b1;
                finish_hit  = LM_FINISH;
                timeout_hit = !LM_FINISH && (to_cnt_reg == TO_LAST);
                done_int    = LM_FINISH && queue_empty && !push_ok;
            end
            default: begin
                busy_int = 1'b0;
            end
        endcase
    end

    assign LM_START = issue && SOFT_RESET;
    assign BUSY     = busy_int && SOFT_RESET;
    assign DONE     = done_int && SOFT_RESET;

    // Pointer and occupancy next values; a timeout flush empties the queue
    // by catching the read pointer up to the write pointer.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (timeout_hit) begin
            rd_ptr_next = wr_ptr_next;
            cnt_next    = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (push_ok && !pop) begin
                cnt_next = cnt_reg + CW'(1);
            end else if (!push_ok && pop) begin
                cnt_next = cnt_reg - CW'(1);
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (soft_clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Command storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= cmd_word;
        end
    end

    // Registered read of the head entry straight into the config outputs.
    // On a full push+pop the old head is read before the slot is overwritten.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            cfg_reg <= '0;
        end else if (soft_clr) begin
            cfg_reg <= '0;
        end else if (pop) begin
            cfg_reg <= mem[rd_ptr_reg];
        end
    end

    // Timeout counter: cleared on issue, counts WAIT cycles without a finish.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            to_cnt_reg <= '0;
        end else if (soft_clr) begin
            to_cnt_reg <= '0;
        end else if (issue || timeout_hit) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == ST_WAIT) && !LM_FINISH) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    // Completed-layer counter, free-running modulo 256.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            layer_cnt_reg <= '0;
        end else if (soft_clr) begin
            layer_cnt_reg <= '0;
        end else if (finish_hit) begin
            layer_cnt_reg <= layer_cnt_reg + 8'd1;
        end
    end

    // Sticky flags; a setting event in the same cycle as ERR_CLR wins.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            err_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (soft_clr) begin
            err_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end else if (ERR_CLR) begin
                err_reg <= 1'b0;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (ERR_CLR) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign CMD_CNT   = cnt_reg;
    assign CMD_FULL  = queue_full;
    assign ERR       = err_reg;
    assign OVF       = ovf_reg;
    assign LAYER_CNT = layer_cnt_reg;
    assign {MSEL_INPUTA_SEL, MSEL_INPUTB_SEL, MSEL_OUTPUTC_SEL,
            M1POS, M1SIZE, M2POS, M3POS} = cfg_reg;

endmodule

// File: tb/tb_npu_sched.sv
// tb_npu_sched: directed scenarios with randomized command contents and
// finish delays, checked against a queue-based model of the scheduler.
module tb_npu_sched;

    localparam int DEPTH   = 4;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 8;

    logic        CLK = 1'b0;
    logic        RESET_X;
    logic        SOFT_RESET;
    logic        CMD_WR;
    logic [1:0]  CMD_A_SEL, CMD_B_SEL, CMD_C_SEL;
    logic [9:0]  CMD_M1POS, CMD_M1SIZE, CMD_M2POS, CMD_M3POS;
    logic        RUN;
    logic        ERR_CLR;
    logic [2:0]  CMD_CNT;
    logic        CMD_FULL, BUSY, DONE, ERR, OVF;
    logic [7:0]  LAYER_CNT;
    logic        LM_START;
    logic        LM_FINISH;
    logic [1:0]  MSEL_INPUTA_SEL, MSEL_INPUTB_SEL, MSEL_OUTPUTC_SEL;
    logic [9:0]  M1POS, M1SIZE, M2POS, M3POS;

    wire [45:0] cfg_obs = {MSEL_INPUTA_SEL, MSEL_INPUTB_SEL, MSEL_OUTPUTC_SEL,
                           M1POS, M1SIZE, M2POS, M3POS};

    npu_sched #(.DEPTH(DEPTH), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET),
        .CMD_WR(CMD_WR), .CMD_A_SEL(CMD_A_SEL), .CMD_B_SEL(CMD_B_SEL),
        .CMD_C_SEL(CMD_C_SEL), .CMD_M1POS(CMD_M1POS), .CMD_M1SIZE(CMD_M1SIZE),
        .CMD_M2POS(CMD_M2POS), .CMD_M3POS(CMD_M3POS), .RUN(RUN),
        .ERR_CLR(ERR_CLR), .CMD_CNT(CMD_CNT), .CMD_FULL(CMD_FULL),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OVF(OVF),
        .LAYER_CNT(LAYER_CNT), .LM_START(LM_START), .LM_FINISH(LM_FINISH),
        .MSEL_INPUTA_SEL(MSEL_INPUTA_SEL), .MSEL_INPUTB_SEL(MSEL_INPUTB_SEL),
        .MSEL_OUTPUTC_SEL(MSEL_OUTPUTC_SEL), .M1POS(M1POS), .M1SIZE(M1SIZE),
        .M2POS(M2POS), .M3POS(M3POS)
    );

    always #5 CLK = ~CLK;

    // Reference model: pending commands in order, plus flags and layer count.
    logic [45:0] model_q[$];
    int          model_layers;
    bit          model_err;
    bit          model_ovf;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [45:0] mk_cmd(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c, input logic [9:0] m1p,
                                           input logic [9:0] m1s, input logic [9:0] m2p,
                                           input logic [9:0] m3p);
        return {a, b, c, m1p, m1s, m2p, m3p};
    endfunction

    function automatic logic [45:0] rand_cmd();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[45:0];
    endfunction

    // Advance to just after the next rising edge and drop one-cycle pulses.
    task automatic tick();
        @(posedge CLK);
        #1;
        CMD_WR    = 1'b0;
        LM_FINISH = 1'b0;
        ERR_CLR   = 1'b0;
    endtask

    task automatic drive_cmd(input logic [45:0] cmd);
        {CMD_A_SEL, CMD_B_SEL, CMD_C_SEL, CMD_M1POS, CMD_M1SIZE, CMD_M2POS, CMD_M3POS} = cmd;
        CMD_WR = 1'b1;
    endtask

    // One push cycle; 'popping' tells the model the head leaves this cycle.
    task automatic push_cmd(input logic [45:0] cmd, input bit popping);
        tick();
        drive_cmd(cmd);
        if (model_q.size() < DEPTH || popping) begin
            model_q.push_back(cmd);
            $display("push cmd=%h accepted", cmd);
        end else begin
            model_ovf = 1'b1;
            $display("push cmd=%h dropped", cmd);
        end
        #1;
    endtask

    // Count cycles to the next LM_START and check the issued configuration.
    task automatic wait_start(input int exp_lat, input string tag);
        int lat;
        logic [45:0] exp_cfg;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            if (LM_START === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        exp_cfg = 46'h0;
        if (model_q.size() > 0) exp_cfg = model_q.pop_front();
        chk({tag, "_cfg"}, cfg_obs, exp_cfg);
        chk({tag, "_cnt"}, CMD_CNT, model_q.size());
        $display("layer start %s cfg=%h cnt=%0d", tag, cfg_obs, CMD_CNT);
    endtask

    // LM_FINISH d cycles after the start pulse.
    task automatic finish_layer(input int d, input string tag);
        for (int i = 1; i < d; i++) begin
            tick();
            #1;
            chk({tag, "_nostart"}, LM_START, 1'b0);
        end
        tick();
        LM_FINISH = 1'b1;
        #1;
        model_layers++;
        chk({tag, "_start_lo"}, LM_START, 1'b0);
        chk({tag, "_done"}, DONE, (model_q.size() == 0));
        $display("layer finish %s delay=%0d done=%0b", tag, d, DONE);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cnt"}, CMD_CNT, 0);
        chk({tag, "_full"}, CMD_FULL, 1'b0);
        chk({tag, "_busy"}, BUSY, 1'b0);
        chk({tag, "_done"}, DONE, 1'b0);
        chk({tag, "_err"}, ERR, 1'b0);
        chk({tag, "_ovf"}, OVF, 1'b0);
        chk({tag, "_layers"}, LAYER_CNT, 0);
        chk({tag, "_start"}, LM_START, 1'b0);
        chk({tag, "_cfg"}, cfg_obs, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        checks = 0;
        errors = 0;
        model_layers = 0;
        model_err = 1'b0;
        model_ovf = 1'b0;
        RESET_X = 1'b0;
        SOFT_RESET = 1'b1;
        CMD_WR = 1'b0;
        RUN = 1'b0;
        ERR_CLR = 1'b0;
        LM_FINISH = 1'b0;
        {CMD_A_SEL, CMD_B_SEL, CMD_C_SEL, CMD_M1POS, CMD_M1SIZE, CMD_M2POS, CMD_M3POS} = '0;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RESET_X = 1'b1;

        // Two layers back to back, finish 5 cycles after each start.
        push_cmd(mk_cmd(2'd1, 2'd2, 2'd3, 10'd10, 10'd64, 10'd0, 10'd100), 1'b0);
        push_cmd(mk_cmd(2'd1, 2'd2, 2'd3, 10'd20, 10'd64, 10'd0, 10'd100), 1'b0);
        tick();
        RUN = 1'b1;
        #1;
        chk("t1_cnt", CMD_CNT, model_q.size());
        wait_start(2, "t1a");
        finish_layer(5, "t1a");
        wait_start(2, "t1b");
        finish_layer(5, "t1b");
        tick();
        #1;
        chk("t1_done_pulse", DONE, 1'b0);
        chk("t1_busy", BUSY, 1'b0);
        chk("t1_layers", LAYER_CNT, model_layers);
        chk("t1_cnt_end", CMD_CNT, model_q.size());
        RUN = 1'b0;

        // Overflow: five pushes into four slots, fifth alongside ERR_CLR.
        for (int k = 0; k < 5; k++) begin
            push_cmd(rand_cmd(), 1'b0);
        end
        ERR_CLR = 1'b1;
        tick();
        #1;
        chk("t2_full", CMD_FULL, (model_q.size() == DEPTH));
        chk("t2_cnt", CMD_CNT, model_q.size());
        chk("t2_ovf_set", OVF, model_ovf);
        tick();
        ERR_CLR = 1'b1;
        model_ovf = 1'b0;
        tick();
        #1;
        chk("t2_ovf_clr", OVF, model_ovf);
        chk("t2_cnt_keep", CMD_CNT, model_q.size());

        // Push into a full queue during the LOAD pop.
        tick();
        RUN = 1'b1;
        #1;
        push_cmd(rand_cmd(), 1'b1);
        chk("t3_busy", BUSY, 1'b1);
        wait_start(1, "t3a");
        chk("t3_ovf", OVF, model_ovf);
        finish_layer(int'($urandom_range(1, 5)), "t3a");
        for (int k = 0; k < 4; k++) begin
            wait_start(2, "t3b");
            finish_layer(int'($urandom_range(1, 5)), "t3b");
        end
        tick();
        #1;
        chk("t3_busy_end", BUSY, 1'b0);
        chk("t3_layers", LAYER_CNT, model_layers);
        chk("t3_cnt_end", CMD_CNT, model_q.size());
        RUN = 1'b0;

        // RUN dropped during a layer with two entries still queued.
        for (int k = 0; k < 3; k++) begin
            push_cmd(rand_cmd(), 1'b0);
        end
        tick();
        RUN = 1'b1;
        #1;
        wait_start(2, "t4a");
        RUN = 1'b0;
        finish_layer(3, "t4a");
        tick();
        #1;
        chk("t4_idle", BUSY, 1'b0);
        chk("t4_cnt", CMD_CNT, model_q.size());
        chk("t4_done", DONE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("t4_hold", LM_START, 1'b0);
        end
        tick();
        RUN = 1'b1;
        #1;
        wait_start(2, "t4b");
        finish_layer(2, "t4b");
        wait_start(2, "t4c");
        finish_layer(4, "t4c");
        tick();
        #1;
        chk("t4_layers", LAYER_CNT, model_layers);
        RUN = 1'b0;

        // Timeout: no finish; a second entry pushed mid-wait gets flushed.
        push_cmd(rand_cmd(), 1'b0);
        tick();
        RUN = 1'b1;
        #1;
        wait_start(2, "t5");
        saw_done = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i == 2) begin
                drive_cmd(rand_cmd());
                model_q.push_back(46'h0);
            end
            #1;
            if (DONE === 1'b1) saw_done = 1'b1;
            if (i == TIMEOUT - 1) begin
                chk("t5_err_early", ERR, model_err);
                chk("t5_busy_early", BUSY, 1'b1);
                model_q.delete();
                model_err = 1'b1;
            end
            if (i == TIMEOUT) begin
                chk("t5_err", ERR, model_err);
                chk("t5_busy", BUSY, 1'b0);
                chk("t5_flush", CMD_CNT, model_q.size());
            end
        end
        chk("t5_no_done", saw_done, 1'b0);
        tick();
        LM_FINISH = 1'b1;
        #1;
        chk("t5_late_done", DONE, 1'b0);
        tick();
        #1;
        chk("t5_late_layers", LAYER_CNT, model_layers);
        chk("t5_late_busy", BUSY, 1'b0);

        // With ERR set, pushes are accepted but nothing starts until cleared.
        push_cmd(rand_cmd(), 1'b0);
        tick();
        #1;
        chk("t5_err_push", CMD_CNT, model_q.size());
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("t5_err_blocked", BUSY, 1'b0);
        end
        tick();
        ERR_CLR = 1'b1;
        model_err = 1'b0;
        #1;
        wait_start(3, "t5c");
        chk("t5_err_clr", ERR, model_err);
        finish_layer(2, "t5c");
        RUN = 1'b0;

        // Asynchronous reset in the middle of a layer.
        push_cmd(rand_cmd(), 1'b0);
        push_cmd(rand_cmd(), 1'b0);
        tick();
        RUN = 1'b1;
        #1;
        wait_start(2, "t6");
        tick();
        tick();
        RESET_X = 1'b0;
        #1;
        model_q.delete();
        model_layers = 0;
        model_err = 1'b0;
        model_ovf = 1'b0;
        check_zero("t6_rst");
        tick();
        RESET_X = 1'b1;
        RUN = 1'b0;
        #1;
        tick();
        LM_FINISH = 1'b1;
        #1;
        chk("t6_late_done", DONE, 1'b0);
        tick();
        #1;
        chk("t6_layers", LAYER_CNT, model_layers);
        chk("t6_busy", BUSY, 1'b0);
        chk("t6_cnt", CMD_CNT, model_q.size());

        // Synchronous soft reset empties the queue at the next edge.
        push_cmd(rand_cmd(), 1'b0);
        tick();
        SOFT_RESET = 1'b0;
        #1;
        chk("t7_cnt_before", CMD_CNT, model_q.size());
        tick();
        SOFT_RESET = 1'b1;
        #1;
        model_q.delete();
        chk("t7_cnt_after", CMD_CNT, model_q.size());
        chk("t7_full", CMD_FULL, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
